// File: rtl/rd_wrptr_sync_status.sv
// rd_wrptr_sync_status
// Read-domain receiver for the async FIFO write pointer: multi-flop Gray
// synchronizer, Gray-to-binary conversion, and registered read-side status
// (fill count, almost-empty, write-advance pulse, sticky overrun error).
// SYNC_STAGES is meant to be 2..4; fewer than 2 flops gives no metastability
// protection.
module rd_wrptr_sync_status #(
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 rdclk,
    input  logic                 rdrst_n,
    input  logic [PTR_WIDTH:0]   g_wrptr_async,
    input  logic [PTR_WIDTH:0]   b_rdptr,
    input  logic [PTR_WIDTH:0]   ae_level,
    input  logic                 clr_err,
    output logic [PTR_WIDTH:0]   g_wrptr_sync,
    output logic [PTR_WIDTH:0]   b_wrptr_sync,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 almost_empty,
    output logic                 wr_adv,
    output logic                 ptr_err
);

    localparam int               DEPTH_I = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH = DEPTH_I[PTR_WIDTH:0];

    logic [SYNC_STAGES-1:0][PTR_WIDTH:0] r_sync;
    logic [PTR_WIDTH:0] w_bin;
    logic [PTR_WIDTH:0] w_diff;
    logic [PTR_WIDTH:0] w_cnt;
    logic               w_over;
    logic [PTR_WIDTH:0] r_b_wrptr;
    logic [PTR_WIDTH:0] r_count;
    logic               r_ae;
    logic               r_adv;
    logic               r_err;

    // Synchronizer chain: plain flop-to-flop, no logic between stages
    always_ff @(posedge rdclk or negedge rdrst_n) begin
        if (!rdrst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= g_wrptr_async;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
        end
    end

    assign g_wrptr_sync = r_sync[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_bin            = '0;
        w_bin[PTR_WIDTH] = g_wrptr_sync[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--)
            w_bin[i] = w_bin[i+1] ^ g_wrptr_sync[i];
    end

    // Modulo subtraction handles pointer wrap; anything beyond depth is an overrun
    assign w_diff = w_bin - b_rdptr;
    assign w_over = (w_diff > DEPTH);
    assign w_cnt  = w_over ? DEPTH : w_diff;

    // Status stage: binary pointer, count, almost-empty and advance pulse
    always_ff @(posedge rdclk or negedge rdrst_n) begin
        if (!rdrst_n) begin
            r_b_wrptr <= '0;
            r_count   <= '0;
            r_ae      <= 1'b1;
            r_adv     <= 1'b0;
        end else begin
            r_b_wrptr <= w_bin;
            r_count   <= w_cnt;
            r_ae      <= (w_cnt <= ae_level);
            r_adv     <= (w_bin != r_b_wrptr);
        end
    end

    // Sticky overrun error: a fresh overrun wins over a clear request
    always_ff @(posedge rdclk or negedge rdrst_n) begin
        if (!rdrst_n)
            r_err <= 1'b0;
        else if (w_over)
            r_err <= 1'b1;
        else if (clr_err)
            r_err <= 1'b0;
    end

    assign b_wrptr_sync = r_b_wrptr;
    assign rd_count     = r_count;
    assign almost_empty = r_ae;
    assign wr_adv       = r_adv;
    assign ptr_err      = r_err;

endmodule
